fsb8_sram_slave: RTL and testbench
==================================

Name: fsb8_sram_slave

Overview:
- Synthesizable, parametrised FSB8 bus slave memory.
- Replaces the behavioural SRAM model used on the FSB8 bus: same multiplexed address/data protocol, but runs synchronous to sysclk.
- Adds an address window decode, programmable wait states driven on rdy_n, and block (burst) transfers with internal address increment.
- Used both as an on-chip scratchpad and as a bench peripheral for the LS1u core.

Parameters:
- ADDR_W, 10: memory depth is 2^ADDR_W bytes; legal range 9..16.
- BASE_ADDR, 24'h000000: base of the decode window; only bits [23:ADDR_W] are compared.
- WAIT_STATES, 1: number of rdy_n-high cycles before each data beat; legal range 0..15.

Ports:
- sysclk  in  1  Single clock; all bus inputs are sampled on its rising edge.
- sysrst  in  1  Reset, synchronous, active-high.
- ale_n  in  1  Address latch enable, low-active.
- cs_n  in  1  Chip select / data phase, low-active.
- wr_n  in  1  0 = write, 1 = read; sampled at each beat.
- typ  in  1  0 = single transfer, 1 = block transfer; sampled on the first cs_n-low cycle.
- aah8_i  in  8  Address phase: addr[23:16]. Data phase: addr[7:0].
- ad_i  in  8  Address phase: addr[15:8]. Data phase: write data.
- ad_o  out  8  Read data.
- ad_oe  out  1  Drive enable for ad_o.
- rdy_n  out  1  Beat complete, low-active, one cycle per beat.
- irq_n  out  1  Mailbox interrupt, low-active. Present only with FSB8_SRAM_IRQ_EN.

Behaviour:
- Reset values: ad_o=0, ad_oe=0, rdy_n=1, irq_n=1. State=IDLE, page register=0, sel=0. Memory contents are not reset.
- State IDLE:
  - ale_n=0: latch page[15:0]={aah8_i,ad_i}. sel=(page[23-8:ADDR_W-8]==BASE_ADDR[23:ADDR_W]). Go to ADDR.
- State ADDR:
  - ale_n=0 again: re-latch the page.
  - cs_n=0 and sel=1: capture lo=aah8_i and mode=typ; load wcnt=WAIT_STATES; go to WAIT.
  - cs_n=0 and sel=0: go to IGNORE. Outputs stay idle until cs_n=1, then IDLE.
- State WAIT:
  - rdy_n=1. wcnt decrements each cycle.
  - When wcnt==0, the memory is read at idx={page[ADDR_W-9:0],lo} and the FSM goes to XFER.
  - With WAIT_STATES=0, XFER follows ADDR directly (one cycle after cs_n is first seen low).
- State XFER (one cycle):
  - rdy_n=0.
  - Read: ad_oe=1 and ad_o=mem[idx].
  - Write: mem[idx]<=ad_i in this cycle; ad_oe=0.
  - Next state:
    - mode=1 and cs_n=0: lo<=lo+1 (mod 256; wraps inside the page, page unchanged), wcnt reloads, go to WAIT.
    - mode=0 and cs_n=0: go to HOLD (idle outputs) until cs_n=1.
    - cs_n=1: go to IDLE.
- ad_oe is high only during a read XFER cycle; it drops the cycle after.
- Abort:
  - cs_n=1 during WAIT: back to IDLE, no memory write, rdy_n stays 1.
  - ale_n=0 in any state other than IDLE: treated as a new address phase (ale has priority). Page is re-latched, go to ADDR, any pending beat is dropped.
- sysrst during a transfer: outputs return to reset values on the next edge; any write not already in XFER is lost.
- wr_n is resampled per beat, so mixed read/write bursts are legal.

Optional Feature:
- Macro FSB8_SRAM_IRQ_EN.
- Defined:
  - The last memory byte (idx = 2^ADDR_W-1) is a mailbox.
  - A write XFER to it sets irq_n=0 on the next cycle.
  - A read XFER of it sets irq_n=1 on the next cycle.
  - Write and read in the same cycle is impossible, since there is a single beat per cycle.
- Undefined: the irq_n port is absent, and the mailbox is ordinary memory.

Decomposition:
- Package fsb8_pkg holds:
  - state enum fsb8_state_t {IDLE, ADDR, WAIT, XFER, HOLD, IGNORE};
  - constants FSB8_AW=24, FSB8_DW=8.
- Sub-module fsb8_spram: single-port, synchronous-read byte RAM (ADDR_W parameter, we, addr, wdata, rdata).
  - The FSM stays in fsb8_sram_slave.

Test Plan:
- Single read, WAIT_STATES=1, BASE=0, mem[0x012]=0xA5: ale with {aah8,ad}={00,00}, then cs_n=0, wr_n=1, aah8=0x12 -> rdy_n low 2 cycles after cs_n first low, ad_oe=1, ad_o=0xA5 for exactly one cycle.
- Block write then block read: write 4 bytes 11,22,33,44 starting at lo=0xFE -> stored at 0xFE, 0xFF, 0x00, 0x01 of the same page (wrap). Read-back burst returns 11,22,33,44, with one rdy_n pulse per beat spaced WAIT_STATES+1 cycles.
- Decode miss: BASE=24'h010000, ale {00,00} then cs_n=0 for 10 cycles -> rdy_n=1, ad_oe=0 throughout, memory unchanged.
- Abort: cs_n deasserted during WAIT with WAIT_STATES=3 on a write of 0x5A -> no rdy_n pulse, target byte unchanged, FSM in IDLE.
- Reset mid-burst: sysrst=1 during a block read -> next cycle rdy_n=1, ad_oe=0, ad_o=0. A following fresh single read works.
- FSB8_SRAM_IRQ_EN, ADDR_W=10: write 0x01 to idx 0x3FF -> irq_n=0 on the cycle after XFER. Read of 0x3FF returns 0x01 and irq_n=1 on the next cycle.

Source files
------------

// File: rtl/fsb8_pkg.sv
// fsb8_pkg: shared types and constants for the FSB8 slave memory.
//   fsb8_state_t : bus slave FSM states
//   FSB8_AW      : full FSB8 address width (bits)
//   FSB8_DW      : FSB8 data width (bits)
package fsb8_pkg;

    localparam int FSB8_AW = 24;
    localparam int FSB8_DW = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WAIT   = 3'd2,
        XFER   = 3'd3,
        HOLD   = 3'd4,
        IGNORE = 3'd5
    } fsb8_state_t;

endpackage

// File: rtl/fsb8_spram.sv
// fsb8_spram: single-port byte RAM with synchronous read (read-first).
//   sysclk : clock
//   we     : write enable, writes wdata to addr on the rising edge
//   addr   : byte index
//   wdata  : write data
//   rdata  : registered read data of addr (old contents on a write)
module fsb8_spram
    import fsb8_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               sysclk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [FSB8_DW-1:0] wdata,
    output logic [FSB8_DW-1:0] rdata
);

    logic [FSB8_DW-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge sysclk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fsb8_sram_slave.sv
// fsb8_sram_slave: synthesizable FSB8 bus slave memory, synchronous to sysclk.
// Multiplexed address/data bus with window decode, programmable wait states
// on rdy_n and block transfers with an address increment that wraps in the page.
//   sysclk  : clock, all bus inputs sampled on the rising edge
//   sysrst  : synchronous active-high reset
//   ale_n   : address latch enable (low); latches addr[23:8] = {aah8_i, ad_i}
//   cs_n    : chip select / data phase (low); aah8_i carries addr[7:0]
//   wr_n    : 0 = write, 1 = read, sampled per beat
//   typ     : 0 = single, 1 = block transfer, sampled on first cs_n-low cycle
//   aah8_i  : address high byte / low address byte
//   ad_i    : address middle byte / write data
//   ad_o    : read data (zero when not driving)
//   ad_oe   : drive enable for ad_o, high only in a read beat cycle
//   rdy_n   : beat complete, one low cycle per beat
//   irq_n   : mailbox interrupt (only when FSB8_SRAM_IRQ_EN is defined)
// Build option: define FSB8_SRAM_IRQ_EN to turn the last byte into a mailbox.
module fsb8_sram_slave
    import fsb8_pkg::*;
#(
    parameter int                 ADDR_W      = 10,
    parameter logic [FSB8_AW-1:0] BASE_ADDR   = 24'h000000,
    parameter int                 WAIT_STATES = 1
) (
    input  logic               sysclk,
    input  logic               sysrst,
    input  logic               ale_n,
    input  logic               cs_n,
    input  logic               wr_n,
    input  logic               typ,
    input  logic [FSB8_DW-1:0] aah8_i,
    input  logic [FSB8_DW-1:0] ad_i,
    output logic [FSB8_DW-1:0] ad_o,
    output logic               ad_oe,
    output logic               rdy_n
`ifdef FSB8_SRAM_IRQ_EN
    ,
    output logic               irq_n
`endif
);

    // WAIT lasts exactly WAIT_STATES cycles: the counter is loaded with one
    // less and XFER is entered from the cycle in which it reads zero.
    localparam logic [3:0] WLOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    fsb8_state_t        state;
    logic [15:0]        page;
    logic               sel;
    logic [7:0]         lo;
    logic               mode;
    logic [3:0]         wcnt;
    logic               is_rd;

    logic [15:0]        page_in;
    logic               sel_in;
    logic [ADDR_W-1:0]  xfer_idx;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [FSB8_DW-1:0] ram_rdata;

    assign page_in  = {aah8_i, ad_i};
    assign sel_in   = (page_in[15:ADDR_W-8] == BASE_ADDR[FSB8_AW-1:ADDR_W]);
    assign xfer_idx = {page[ADDR_W-9:0], lo};

    // The single RAM port is shared between reads and writes. In ADDR the
    // low byte comes straight from the bus so a zero-wait first beat has its
    // data ready. During a read XFER the port prefetches the next byte so
    // zero-wait read bursts can run back to back.
    always_comb begin
        ram_addr = xfer_idx;
        ram_we   = 1'b0;
        case (state)
            ADDR: ram_addr = {page[ADDR_W-9:0], aah8_i};
            XFER: begin
                if (is_rd) begin
                    ram_addr = {page[ADDR_W-9:0], lo + 8'd1};
                end else begin
                    ram_we   = 1'b1;
                end
            end
            default: ram_addr = xfer_idx;
        endcase
    end

    fsb8_spram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .sysclk (sysclk),
        .we     (ram_we),
        .addr   (ram_addr),
        .wdata  (ad_i),
        .rdata  (ram_rdata)
    );

    // ad_oe and the RAM output register are both updated on the edge that
    // enters XFER, so gating is enough to present the read byte in-cycle.
    assign ad_o = ad_oe ? ram_rdata : '0;

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state <= IDLE;
            page  <= '0;
            sel   <= 1'b0;
            is_rd <= 1'b0;
            rdy_n <= 1'b1;
            ad_oe <= 1'b0;
`ifdef FSB8_SRAM_IRQ_EN
            irq_n <= 1'b1;
`endif
        end else begin
            rdy_n <= 1'b1;
            ad_oe <= 1'b0;

`ifdef FSB8_SRAM_IRQ_EN
            // Mailbox: a write beat raises the interrupt, a read beat clears it.
            if (state == XFER && xfer_idx == '1) begin
                irq_n <= is_rd;
            end
`endif

            // A new address phase wins over anything in progress.
            if (!ale_n) begin
                page  <= page_in;
                sel   <= sel_in;
                state <= ADDR;
            end else begin
                case (state)
                    IDLE: state <= IDLE;

                    ADDR: begin
                        if (!cs_n) begin
                            if (sel) begin
                                lo   <= aah8_i;
                                mode <= typ;
                                wcnt <= WLOAD;
                                if (WAIT_STATES == 0) begin
                                    state <= XFER;
                                    is_rd <= wr_n;
                                    rdy_n <= 1'b0;
                                    ad_oe <= wr_n;
                                end else begin
                                    state <= WAIT;
                                end
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end

                    WAIT: begin
                        if (cs_n) begin
                            state <= IDLE;
                        end else if (wcnt == 4'd0) begin
                            state <= XFER;
                            is_rd <= wr_n;
                            rdy_n <= 1'b0;
                            ad_oe <= wr_n;
                        end else begin
                            wcnt <= wcnt - 4'd1;
                        end
                    end

                    XFER: begin
                        if (cs_n) begin
                            state <= IDLE;
                        end else if (mode) begin
                            lo   <= lo + 8'd1;
                            wcnt <= WLOAD;
                            // Zero-wait continuation is only possible when this
                            // beat left the RAM port free for the prefetch.
                            if (WAIT_STATES == 0 && is_rd) begin
                                state <= XFER;
                                is_rd <= wr_n;
                                rdy_n <= 1'b0;
                                ad_oe <= wr_n;
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            state <= HOLD;
                        end
                    end

                    HOLD, IGNORE: begin
                        if (cs_n) begin
                            state <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsb8_sram_slave.sv
// tb_fsb8_sram_slave: directed bench for fsb8_sram_slave.
//   u_a : BASE 0, one wait state    (single/burst/reset/mailbox)
//   u_b : BASE 0x010000, one wait   (decode miss)
//   u_c : BASE 0, three wait states (abort)
module tb_fsb8_sram_slave;

    logic       sysclk;
    logic       sysrst;
    logic       ale_n;
    logic       cs_a, cs_b, cs_c;
    logic       wr_n;
    logic       typ;
    logic [7:0] aah8;
    logic [7:0] ad_i;
    logic [7:0] ado_a, ado_b, ado_c;
    logic       oe_a, oe_b, oe_c;
    logic       rdy_a, rdy_b, rdy_c;
`ifdef FSB8_SRAM_IRQ_EN
    logic       irq_a, irq_b, irq_c;
`endif

    int npass = 0;
    int ntotal = 0;
    int nfail = 0;
    logic [7:0] bdat [0:3];

    fsb8_sram_slave #(.ADDR_W(10), .BASE_ADDR(24'h000000), .WAIT_STATES(1)) u_a (
        .sysclk(sysclk), .sysrst(sysrst), .ale_n(ale_n), .cs_n(cs_a), .wr_n(wr_n),
        .typ(typ), .aah8_i(aah8), .ad_i(ad_i), .ad_o(ado_a), .ad_oe(oe_a), .rdy_n(rdy_a)
`ifdef FSB8_SRAM_IRQ_EN
        , .irq_n(irq_a)
`endif
    );

    fsb8_sram_slave #(.ADDR_W(10), .BASE_ADDR(24'h010000), .WAIT_STATES(1)) u_b (
        .sysclk(sysclk), .sysrst(sysrst), .ale_n(ale_n), .cs_n(cs_b), .wr_n(wr_n),
        .typ(typ), .aah8_i(aah8), .ad_i(ad_i), .ad_o(ado_b), .ad_oe(oe_b), .rdy_n(rdy_b)
`ifdef FSB8_SRAM_IRQ_EN
        , .irq_n(irq_b)
`endif
    );

    fsb8_sram_slave #(.ADDR_W(10), .BASE_ADDR(24'h000000), .WAIT_STATES(3)) u_c (
        .sysclk(sysclk), .sysrst(sysrst), .ale_n(ale_n), .cs_n(cs_c), .wr_n(wr_n),
        .typ(typ), .aah8_i(aah8), .ad_i(ad_i), .ad_o(ado_c), .ad_oe(oe_c), .rdy_n(rdy_c)
`ifdef FSB8_SRAM_IRQ_EN
        , .irq_n(irq_c)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        ntotal++;
        assert (o === e) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic set_cs(input int w, input logic v);
        case (w)
            0:       cs_a = v;
            1:       cs_b = v;
            default: cs_c = v;
        endcase
    endtask

    function automatic logic rdy_of(input int w);
        case (w)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic oe_of(input int w);
        case (w)
            0:       return oe_a;
            1:       return oe_b;
            default: return oe_c;
        endcase
    endfunction

    function automatic logic [7:0] ado_of(input int w);
        case (w)
            0:       return ado_a;
            1:       return ado_b;
            default: return ado_c;
        endcase
    endfunction

    // Address phase: drive addr[23:8] with ale_n low for one edge.
    task automatic addr_phase(input logic [23:0] a);
        @(negedge sysclk);
        ale_n = 1'b0;
        aah8  = a[23:16];
        ad_i  = a[15:8];
        @(negedge sysclk);
        ale_n = 1'b1;
    endtask

    // Single transfer; for reads d is the expected byte.
    task automatic single(input int w, input logic [23:0] a, input logic rd,
                          input logic [7:0] d, input int ws, input string tag);
        int k;
        addr_phase(a);
        set_cs(w, 1'b0);
        wr_n = rd;
        typ  = 1'b0;
        aah8 = a[7:0];
        ad_i = d;
        k = 0;
        do begin
            @(negedge sysclk);
            k++;
        end while (rdy_of(w) !== 1'b0 && k < 20);
        chk({tag, "_lat"}, k, ws + 1);
        chk({tag, "_oe"}, oe_of(w), rd);
        if (rd) chk({tag, "_data"}, ado_of(w), d);
        set_cs(w, 1'b1);
        @(negedge sysclk);
        chk({tag, "_end"}, {rdy_of(w), oe_of(w), ado_of(w)}, {1'b1, 1'b0, 8'h00});
    endtask

    // Block transfer of n beats using bdat[] (write data or expected read data).
    task automatic burst(input int w, input logic [23:0] a, input int n,
                         input logic rd, input int ws, input string tag);
        int k;
        addr_phase(a);
        set_cs(w, 1'b0);
        wr_n = rd;
        typ  = 1'b1;
        aah8 = a[7:0];
        ad_i = bdat[0];
        for (int i = 0; i < n; i++) begin
            k = 0;
            do begin
                @(negedge sysclk);
                k++;
                if (k == 1 && i > 0) ad_i = bdat[i];
            end while (rdy_of(w) !== 1'b0 && k < 20);
            chk($sformatf("%s_sp%0d", tag, i), k, ws + 1);
            chk($sformatf("%s_oe%0d", tag, i), oe_of(w), rd);
            if (rd) chk($sformatf("%s_d%0d", tag, i), ado_of(w), bdat[i]);
            if (i == n - 1) set_cs(w, 1'b1);
        end
        @(negedge sysclk);
        chk({tag, "_end"}, {rdy_of(w), oe_of(w)}, 2'b10);
        typ = 1'b0;
    endtask

    initial begin
        int k;
        sysrst = 1'b1;
        ale_n  = 1'b1;
        cs_a   = 1'b1;
        cs_b   = 1'b1;
        cs_c   = 1'b1;
        wr_n   = 1'b1;
        typ    = 1'b0;
        aah8   = 8'h00;
        ad_i   = 8'h00;
        repeat (3) @(negedge sysclk);
        chk("reset_a", {rdy_a, oe_a, ado_a}, {1'b1, 1'b0, 8'h00});
        chk("reset_b", {rdy_b, oe_b}, 2'b10);
        chk("reset_c", {rdy_c, oe_c}, 2'b10);
`ifdef FSB8_SRAM_IRQ_EN
        chk("reset_irq", irq_a, 1'b1);
`endif
        sysrst = 1'b0;
        @(negedge sysclk);

        // Single write then single read of 0x012.
        single(0, 24'h000012, 1'b0, 8'hA5, 1, "wr012");
        single(0, 24'h000012, 1'b1, 8'hA5, 1, "rd012");

        // Block write wrapping inside the page, then read back.
        bdat[0] = 8'h11; bdat[1] = 8'h22; bdat[2] = 8'h33; bdat[3] = 8'h44;
        burst(0, 24'h0000FE, 4, 1'b0, 1, "bwr");
        burst(0, 24'h0000FE, 4, 1'b1, 1, "brd");
        single(0, 24'h000000, 1'b1, 8'h33, 1, "wrap00");
        single(0, 24'h0000FF, 1'b1, 8'h22, 1, "wrapff");

        // Decode miss: prime a hit byte, then hammer the aliased miss address.
        single(1, 24'h010012, 1'b0, 8'h3C, 1, "b_wr");
        addr_phase(24'h000012);
        cs_b = 1'b0;
        wr_n = 1'b0;
        aah8 = 8'h12;
        ad_i = 8'h77;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            chk($sformatf("miss_%0d", i), {rdy_b, oe_b}, 2'b10);
        end
        cs_b = 1'b1;
        @(negedge sysclk);
        single(1, 24'h010012, 1'b1, 8'h3C, 1, "b_rd");

        // Abort during WAIT with three wait states.
        single(2, 24'h000040, 1'b0, 8'hC3, 3, "c_wr");
        addr_phase(24'h000040);
        cs_c = 1'b0;
        wr_n = 1'b0;
        aah8 = 8'h40;
        ad_i = 8'h5A;
        @(negedge sysclk);
        chk("abort_wait", rdy_c, 1'b1);
        cs_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            chk($sformatf("abort_%0d", i), {rdy_c, oe_c}, 2'b10);
        end
        single(2, 24'h000040, 1'b1, 8'hC3, 3, "c_rd");

        // Reset in the wait before the second beat of a block read.
        addr_phase(24'h0000FE);
        cs_a = 1'b0;
        wr_n = 1'b1;
        typ  = 1'b1;
        aah8 = 8'hFE;
        k = 0;
        do begin
            @(negedge sysclk);
            k++;
        end while (rdy_a !== 1'b0 && k < 20);
        chk("rst_b0_lat", k, 2);
        chk("rst_b0_data", {oe_a, ado_a}, {1'b1, 8'h11});
        @(negedge sysclk);
        sysrst = 1'b1;
        @(negedge sysclk);
        chk("rst_mid", {rdy_a, oe_a, ado_a}, {1'b1, 1'b0, 8'h00});
        sysrst = 1'b0;
        cs_a   = 1'b1;
        typ    = 1'b0;
        @(negedge sysclk);
        chk("rst_idle", {rdy_a, oe_a}, 2'b10);
        single(0, 24'h000012, 1'b1, 8'hA5, 1, "post_rst");

`ifdef FSB8_SRAM_IRQ_EN
        single(0, 24'h0003FF, 1'b0, 8'h01, 1, "mbox_wr");
        chk("irq_set", irq_a, 1'b0);
        single(0, 24'h0003FF, 1'b1, 8'h01, 1, "mbox_rd");
        chk("irq_clr", irq_a, 1'b1);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
